// File: rtl/pipe_issue_arbiter.sv
// Round-robin issue arbiter for a shared fixed-latency, always-accepting pipe.
// A tag line matched to the pipe latency returns a per-requester done pulse.
module pipe_issue_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 32,
   parameter  int LATENCY = 3,
   parameter  int MAX_OUT = 3,
   localparam int ID_W    = $clog2(NUM_REQ),
   localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      issue_en_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic                      pipe_in_valid_o,
   output logic [DATA_W-1:0]         pipe_in_data_o,
   output logic [ID_W-1:0]           pipe_in_id_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic [CNT_W-1:0]          inflight_o
);

   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic              pipe_vld_q;
   logic [DATA_W-1:0] pipe_dat_q;
   logic [ID_W-1:0]   pipe_id_q;
   logic [LATENCY-1:0] tag_vld_q;
   logic [ID_W-1:0]   tag_id_q [LATENCY];
   logic [CNT_W-1:0]  inflight_q, inflight_d;

   logic              found;
   logic [ID_W-1:0]   win;
   logic [ID_W:0]     sum;
   logic [ID_W-1:0]   idx;
   logic              grant;
   logic              retire;

   assign retire = tag_vld_q[LATENCY-1];

   // Lowest offset from ptr_q wins; the explicit wrap keeps non-power-of-two counts correct.
   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
         end
         idx = sum[ID_W-1:0];
         if (!found && req_valid_i[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // A retiring op frees its slot in the same cycle, so a full window can still issue.
   assign grant = rst_n && issue_en_i && found &&
                  ((inflight_q < CNT_W'(MAX_OUT)) || retire);

   always_comb begin
      req_ready_o = '0;
      ptr_d       = ptr_q;
      inflight_d  = inflight_q;
      if (grant) begin
         req_ready_o = NUM_REQ'(1) << win;
         ptr_d       = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
      end
      case ({grant, retire})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         inflight_q <= '0;
         pipe_vld_q <= 1'b0;
         pipe_dat_q <= '0;
         pipe_id_q  <= '0;
         tag_vld_q  <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            tag_id_q[i] <= '0;
         end
      end else begin
         ptr_q      <= ptr_d;
         inflight_q <= inflight_d;
         pipe_vld_q <= grant;
         if (grant) begin
            pipe_dat_q <= req_data_i[int'(win)*DATA_W +: DATA_W];
            pipe_id_q  <= win;
         end
         tag_vld_q[0] <= pipe_vld_q;
         tag_id_q[0]  <= pipe_id_q;
         for (int i = 1; i < LATENCY; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
            tag_id_q[i]  <= tag_id_q[i-1];
         end
      end
   end

   assign pipe_in_valid_o = pipe_vld_q;
   assign pipe_in_data_o  = pipe_dat_q;
   assign pipe_in_id_o    = pipe_id_q;
   assign done_o          = retire ? (NUM_REQ'(1) << tag_id_q[LATENCY-1]) : '0;
   assign inflight_o      = inflight_q;

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Two arbiter instances (full-throughput and throttled window) driven from shared stimulus.
module tb_pipe_issue_arbiter;
   localparam int NR   = 4;
   localparam int DW   = 32;
   localparam int LAT  = 3;
   localparam int MO_A = 4;
   localparam int MO_B = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic issue_en = 1'b0;
   logic [NR-1:0] req_valid = '0;
   logic [NR*DW-1:0] req_data = '0;

   logic [NR-1:0] rdy_a, rdy_b, done_a, done_b;
   logic pv_a, pv_b;
   logic [DW-1:0] pd_a, pd_b;
   logic [1:0] pid_a, pid_b;
   logic [2:0] inf_a;
   logic [1:0] inf_b;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_issue_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LATENCY(LAT), .MAX_OUT(MO_A)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .issue_en_i(issue_en), .req_valid_i(req_valid),
      .req_data_i(req_data), .req_ready_o(rdy_a), .pipe_in_valid_o(pv_a),
      .pipe_in_data_o(pd_a), .pipe_in_id_o(pid_a), .done_o(done_a), .inflight_o(inf_a));

   pipe_issue_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LATENCY(LAT), .MAX_OUT(MO_B)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .issue_en_i(issue_en), .req_valid_i(req_valid),
      .req_data_i(req_data), .req_ready_o(rdy_b), .pipe_in_valid_o(pv_b),
      .pipe_in_data_o(pd_b), .pipe_in_id_o(pid_b), .done_o(done_b), .inflight_o(inf_b));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Reference model: pointer, occupancy count, last issue, and done events keyed by due cycle.
   int          m_ptr [2] = '{0, 0};
   int          m_inf [2] = '{0, 0};
   int          m_pid [2] = '{0, 0};
   logic        m_pv  [2] = '{1'b0, 1'b0};
   logic [DW-1:0] m_pd [2] = '{'0, '0};
   int          sched [longint];
   longint      cyc = 0;

   always @(negedge clk) begin
      int mo, w, idx, inf_act;
      longint key;
      logic retire, pv_act;
      logic [NR-1:0] done_e, rdy_e, rdy_act, done_act;
      logic [DW-1:0] pd_act;
      logic [1:0] pid_act;
      string nm;
      for (int m = 0; m < 2; m++) begin
         mo       = (m == 0) ? MO_A : MO_B;
         nm       = (m == 0) ? "A" : "B";
         rdy_act  = (m == 0) ? rdy_a : rdy_b;
         done_act = (m == 0) ? done_a : done_b;
         pv_act   = (m == 0) ? pv_a : pv_b;
         pd_act   = (m == 0) ? pd_a : pd_b;
         pid_act  = (m == 0) ? pid_a : pid_b;
         inf_act  = (m == 0) ? int'(inf_a) : int'(inf_b);

         key    = cyc * 2 + m;
         done_e = '0;
         if (sched.exists(key)) done_e[sched[key]] = 1'b1;
         retire = (done_e != '0);

         w = -1;
         if (rst_n && issue_en && (m_inf[m] < mo || retire)) begin
            for (int k = 0; k < NR; k++) begin
               idx = (m_ptr[m] + k) % NR;
               if (w < 0 && req_valid[idx]) w = idx;
            end
         end
         rdy_e = '0;
         if (w >= 0) rdy_e[w] = 1'b1;

         chk($sformatf("%s ready @%0d", nm, cyc), rdy_act, rdy_e);
         chk($sformatf("%s done @%0d", nm, cyc), done_act, done_e);
         chk($sformatf("%s pipe_vld @%0d", nm, cyc), pv_act, m_pv[m]);
         chk($sformatf("%s pipe_dat @%0d", nm, cyc), pd_act, m_pd[m]);
         chk($sformatf("%s pipe_id @%0d", nm, cyc), pid_act, m_pid[m]);
         chk($sformatf("%s inflight @%0d", nm, cyc), inf_act, m_inf[m]);

         if (!rst_n) begin
            m_ptr[m] = 0; m_inf[m] = 0; m_pv[m] = 1'b0; m_pd[m] = '0; m_pid[m] = 0;
         end else begin
            if (w >= 0) m_inf[m]++;
            if (retire) m_inf[m]--;
            m_pv[m] = (w >= 0);
            if (w >= 0) begin
               m_pd[m]  = req_data[w*DW +: DW];
               m_pid[m] = w;
               m_ptr[m] = (w + 1) % NR;
               sched[(cyc + 1 + LAT) * 2 + m] = w;
            end
         end
         if (sched.exists(key)) sched.delete(key);
      end
      if (!rst_n) sched.delete();
      cyc++;
   end

   initial begin
      // Reset state, with requests pending to show they are ignored.
      req_valid = 4'b1111;
      issue_en  = 1'b1;
      mid();
      chk("reset ready A", rdy_a, 0);
      chk("reset ready B", rdy_b, 0);
      chk("reset pipe_vld", pv_a, 0);
      chk("reset pipe_dat", pd_a, 0);
      chk("reset pipe_id", pid_a, 0);
      chk("reset done", done_a, 0);
      chk("reset inflight", inf_a, 0);
      tick();
      tick();

      // Single request: issue next cycle, done four cycles after the handshake.
      rst_n = 1'b1;
      req_valid = 4'b0001;
      req_data[31:0] = 32'hA5A5_0001;
      mid();
      chk("single ready", rdy_a, 4'b0001);
      tick();
      req_valid = '0;
      mid();
      chk("single pipe_vld", pv_a, 1);
      chk("single pipe_dat", pd_a, 32'hA5A5_0001);
      chk("single pipe_id", pid_a, 0);
      chk("single inflight", inf_a, 1);
      for (int k = 2; k <= 5; k++) begin
         tick();
         mid();
         chk($sformatf("single done T+%0d", k), done_a, (k == 4) ? 4'b0001 : 4'b0000);
      end

      // Full contention on A: pointer sits at 1 after the grant to 0.
      tick();
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         mid();
         chk($sformatf("contend ready k%0d", k), rdy_a, 1 << ((k + 1) % 4));
         if (k >= 4) chk($sformatf("contend done k%0d", k), done_a, 1 << ((k - 3) % 4));
         tick();
      end
      req_valid = '0;
      repeat (5) tick();

      // Throttle on B (window of 2).
      req_valid = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         mid();
         chk($sformatf("throttle ready k%0d", k), rdy_b, (k == 2 || k == 3) ? 4'b0000 : 4'b0001);
         if (k == 2) chk("throttle inflight", inf_b, 2);
         tick();
      end
      req_valid = '0;
      repeat (6) tick();

      // Two ops in flight, then issue paused for five cycles.
      req_valid = 4'b0011;
      repeat (2) tick();
      issue_en = 1'b0;
      req_valid = 4'b1111;
      for (int d = 0; d < 5; d++) begin
         mid();
         chk($sformatf("pause ready d%0d", d), rdy_a, 0);
         chk($sformatf("pause done d%0d", d), $countones(done_a), (d == 2 || d == 3) ? 1 : 0);
         if (d == 4) chk("pause drained", inf_a, 0);
         tick();
      end

      // Wrap-around.
      issue_en = 1'b1;
      req_valid = 4'b0100;
      mid();
      chk("wrap grant 2", rdy_a, 4'b0100);
      tick();
      req_valid = 4'b0101;
      mid();
      chk("wrap grant 0", rdy_a, 4'b0001);
      tick();
      req_valid = 4'b0110;
      mid();
      chk("wrap ptr 1", rdy_a, 4'b0010);
      tick();
      req_valid = '0;

      // Reset one cycle after a grant.
      req_valid = 4'b0001;
      mid();
      chk("rst grant", rdy_a, 4'b0001);
      tick();
      req_valid = '0;
      rst_n = 1'b0;
      mid();
      chk("rst pre pipe_vld", pv_a, 1);
      tick();
      rst_n = 1'b1;
      mid();
      chk("rst post pipe_vld", pv_a, 0);
      chk("rst post pipe_dat", pd_a, 0);
      chk("rst post pipe_id", pid_a, 0);
      chk("rst post inflight", inf_a, 0);
      chk("rst post done", done_a, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         mid();
         chk($sformatf("rst no done k%0d", k), done_a, 0);
      end
      tick();
      req_valid = 4'b1111;
      mid();
      chk("rst ptr restart", rdy_a, 4'b0001);
      tick();

      // Randomized traffic, enable pauses and occasional resets.
      repeat (3000) begin
         req_valid = NR'($urandom_range(0, 15));
         for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
         issue_en = ($urandom_range(0, 7) != 0);
         rst_n    = ($urandom_range(0, 149) != 0);
         tick();
      end
      req_valid = '0;
      rst_n = 1'b1;
      repeat (8) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
